prefetch_ar_arbiter: RTL and testbench
======================================

// Module: prefetch_ar_arbiter
// PURPOSE
//  Shares the single DDR read channel (AR + R) between two masters: port P (prefetcherTop m_ar/m_r side)
//  and port B (bypass path for reads outside [bar,limit]). Round-robin arbitration on AR, registered AR
//  output, in-order R routing via a source-tag FIFO. Sits between prefetcherTop/bypass and axi_ram.
// PARAMETERS
//  ADDR_BITS        16  AR address width
//  BURST_LEN_WIDTH  8   AR len width
//  TID_WIDTH        8   transaction ID width
//  DATA_WIDTH       8   R data width
//  LOG_OUTSTANDING  2   log2 of max outstanding bursts (tag FIFO depth 2^LOG_OUTSTANDING)
// PORTS
//  clk             in   1                clock
//  resetN          in   1                async reset, active-low
//  p_ar_valid/ready  in/out 1            port P AR handshake
//  p_ar_addr/len/id  in  ADDR/BURST/TID  port P AR payload
//  b_ar_valid/ready  in/out 1            port B AR handshake
//  b_ar_addr/len/id  in  ADDR/BURST/TID  port B AR payload
//  m_ar_valid/ready  out/in 1            DDR AR handshake
//  m_ar_addr/len/id  out ADDR/BURST/TID  DDR AR payload (registered)
//  m_r_valid/ready/last in/out/in 1      DDR R handshake
//  m_r_data/id     in   DATA/TID         DDR R payload
//  p_r_valid/ready/last out/in/out 1     port P R channel; p_r_data/id out DATA/TID
//  b_r_valid/ready/last out/in/out 1     port B R channel; b_r_data/id out DATA/TID
//  outstanding     out  LOG_OUTSTANDING+1  bursts captured but not fully returned
//  err_orphan_r    out  1                sticky: R beat arrived with tag FIFO empty
// BEHAVIOUR
//  Reset (resetN=0, async): state=IDLE, m_ar_valid=0, m_ar_* payload=0, rr_last=B (P wins first tie),
//   FIFO empty, outstanding=0, err_orphan_r=0, p/b_ar_ready=0. In-flight bursts dropped; no recovery.
//  FSM IDLE: x_ar_ready=1 only for the winner, only if FIFO not full. Winner: sole valid requester; if both
//   valid, the one not granted last (rr_last). On accept: latch payload into m_ar_*, push tag (0=P,1=B),
//   update rr_last, -> SEND. No valid or FIFO full: stay IDLE, both readies 0.
//  FSM SEND: m_ar_valid=1, payload stable; both x_ar_ready=0. On m_ar_ready -> IDLE. No capture in same cycle
//   (max AR throughput 1 per 2 cycles; accept-to-m_ar_valid latency 1 cycle).
//  R routing: head tag selects port. Selected x_r_valid=m_r_valid; other x_r_valid=0; data/id/last broadcast.
//   m_r_ready=selected x_r_ready. Pop on m_r_valid&m_r_ready&m_r_last. Non-last beats never pop.
//  FIFO empty: m_r_ready=1 (drain), p/b_r_valid=0; any m_r_valid sets err_orphan_r (cleared only by reset).
//  outstanding: +1 on push, -1 on pop, unchanged on simultaneous push+pop; full = outstanding==2^LOG_OUTSTANDING
//   (push and pop in same cycle when full is impossible: push requires not full). Pointers wrap mod depth.
//  Bursts returned strictly in AR order (axi_ram is in-order); IDs not used for routing.
// TESTING
//  1 P only: p_ar addr=16'h0eef len=0 id=5 -> m_ar_valid next cycle with same payload; R beat -> p_r_valid, b_r_valid=0.
//  2 P,B valid same cycle after reset -> P granted first, B second; R beats routed P then B; outstanding 0->1->2->1->0.
//  3 Fill: 4 B reads len=3 with m_r_valid held 0 -> 5th request ready=0 until first last beat pops; outstanding=4 max.
//  4 Backpressure: p_r_ready=0 during P beat -> m_r_ready=0, data held; B beats not delivered until P burst done.
//  5 Orphan: m_r_valid=1 with FIFO empty -> beat drained, err_orphan_r=1 and stays 1 until resetN=0.
//  6 Reset mid-burst (SEND, outstanding=2) -> m_ar_valid=0, outstanding=0 immediately (async), err cleared.

Source files
------------

// File: rtl/prefetch_ar_arbiter.sv
// Purpose: share one DDR read channel (AR + R) between prefetch port P and bypass port B.
// Latency: AR accept to m_ar_valid 1 cycle, at most one AR every 2 cycles; R path is combinational.
// Backpressure: AR ready drops while an AR is held or the tag FIFO is full; m_r_ready follows the owning port's r_ready.
//
// Ports:
//   clk, resetN                 clock, asynchronous active-low reset
//   p_ar_* / b_ar_*             AR requests from port P and port B (valid/ready + addr/len/id)
//   m_ar_*                      registered AR toward DDR
//   m_r_*                       R beats from DDR (valid/ready/last + data/id)
//   p_r_* / b_r_*               R beats routed to the owning port
//   outstanding                 bursts accepted but not yet fully returned
//   err_orphan_r                sticky flag: R beat seen with no burst outstanding
module prefetch_ar_arbiter #(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       p_ar_valid,
    output logic                       p_ar_ready,
    input  logic [ADDR_BITS-1:0]       p_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
    input  logic [TID_WIDTH-1:0]       p_ar_id,
    input  logic                       b_ar_valid,
    output logic                       b_ar_ready,
    input  logic [ADDR_BITS-1:0]       b_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] b_ar_len,
    input  logic [TID_WIDTH-1:0]       b_ar_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic                       m_r_last,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic [TID_WIDTH-1:0]       m_r_id,
    output logic                       p_r_valid,
    input  logic                       p_r_ready,
    output logic                       p_r_last,
    output logic [DATA_WIDTH-1:0]      p_r_data,
    output logic [TID_WIDTH-1:0]       p_r_id,
    output logic                       b_r_valid,
    input  logic                       b_r_ready,
    output logic                       b_r_last,
    output logic [DATA_WIDTH-1:0]      b_r_data,
    output logic [TID_WIDTH-1:0]       b_r_id,
    output logic [LOG_OUTSTANDING:0]   outstanding,
    output logic                       err_orphan_r
);

    localparam int DEPTH = 1 << LOG_OUTSTANDING;

    typedef struct packed {
        logic [ADDR_BITS-1:0]       addr;
        logic [BURST_LEN_WIDTH-1:0] len;
        logic [TID_WIDTH-1:0]       id;
    } ar_t;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state;
    ar_t                        ar_q;
    logic                       rr_last_b;   // 1: B was granted last, so P wins the next tie
    logic [DEPTH-1:0]           tag_mem;     // 0 = P, 1 = B, one entry per outstanding burst
    logic [LOG_OUTSTANDING-1:0] wr_ptr;
    logic [LOG_OUTSTANDING-1:0] rd_ptr;

    logic fifo_full;
    logic fifo_empty;
    logic head_b;
    logic p_win;
    logic b_win;
    logic push;
    logic pop;

    assign fifo_full  = (outstanding == (LOG_OUTSTANDING+1)'(DEPTH));
    assign fifo_empty = (outstanding == '0);
    assign head_b     = tag_mem[rd_ptr];

    // Round-robin: on a tie the port that was not granted last wins.
    assign p_win = p_ar_valid & (~b_ar_valid | rr_last_b);
    assign b_win = b_ar_valid & ~p_win;

    // Reset gates the readies so nothing is offered while the block is held in reset.
    assign p_ar_ready = resetN & (state == IDLE) & ~fifo_full & p_win;
    assign b_ar_ready = resetN & (state == IDLE) & ~fifo_full & b_win;
    assign push       = (p_ar_valid & p_ar_ready) | (b_ar_valid & b_ar_ready);

    assign m_ar_valid = (state == SEND);
    assign m_ar_addr  = ar_q.addr;
    assign m_ar_len   = ar_q.len;
    assign m_ar_id    = ar_q.id;

    // R routing: the oldest outstanding tag owns the channel; with nothing
    // outstanding, beats are drained and flagged as orphans.
    assign p_r_valid = m_r_valid & ~fifo_empty & ~head_b;
    assign b_r_valid = m_r_valid & ~fifo_empty & head_b;
    assign m_r_ready = fifo_empty ? 1'b1 : (head_b ? b_r_ready : p_r_ready);
    assign pop       = ~fifo_empty & m_r_valid & m_r_ready & m_r_last;

    assign p_r_last = m_r_last;
    assign p_r_data = m_r_data;
    assign p_r_id   = m_r_id;
    assign b_r_last = m_r_last;
    assign b_r_data = m_r_data;
    assign b_r_id   = m_r_id;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            ar_q         <= '0;
            rr_last_b    <= 1'b1;
            tag_mem      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            err_orphan_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        ar_q      <= p_win ? ar_t'{p_ar_addr, p_ar_len, p_ar_id}
                                           : ar_t'{b_ar_addr, b_ar_len, b_ar_id};
                        rr_last_b <= b_win;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (m_ar_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tag_mem[wr_ptr] <= b_win;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (fifo_empty && m_r_valid) begin
                err_orphan_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Bench for prefetch_ar_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_prefetch_ar_arbiter;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        p_ar_valid, p_ar_ready;
    logic [15:0] p_ar_addr;
    logic [7:0]  p_ar_len, p_ar_id;
    logic        b_ar_valid, b_ar_ready;
    logic [15:0] b_ar_addr;
    logic [7:0]  b_ar_len, b_ar_id;
    logic        m_ar_valid, m_ar_ready;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [7:0]  m_r_data, m_r_id;
    logic        p_r_valid, p_r_ready, p_r_last;
    logic [7:0]  p_r_data, p_r_id;
    logic        b_r_valid, b_r_ready, b_r_last;
    logic [7:0]  b_r_data, b_r_id;
    logic [2:0]  outstanding;
    logic        err_orphan_r;

    int total = 0;
    int bad   = 0;

    prefetch_ar_arbiter dut (
        .clk(clk), .resetN(resetN),
        .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready), .p_ar_addr(p_ar_addr),
        .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
        .b_ar_valid(b_ar_valid), .b_ar_ready(b_ar_ready), .b_ar_addr(b_ar_addr),
        .b_ar_len(b_ar_len), .b_ar_id(b_ar_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
        .m_r_data(m_r_data), .m_r_id(m_r_id),
        .p_r_valid(p_r_valid), .p_r_ready(p_r_ready), .p_r_last(p_r_last),
        .p_r_data(p_r_data), .p_r_id(p_r_id),
        .b_r_valid(b_r_valid), .b_r_ready(b_r_ready), .b_r_last(b_r_last),
        .b_r_data(b_r_data), .b_r_id(b_r_id),
        .outstanding(outstanding), .err_orphan_r(err_orphan_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One held AR slot, the grant history bit, and a queue of owners (0=P, 1=B)
    // in the order bursts were accepted.
    bit          md_pend;
    logic [15:0] md_addr;
    logic [7:0]  md_len, md_id;
    bit          md_last_b;
    bit          md_tags[$];
    bit          md_err;

    task automatic model_reset();
        md_pend   = 0;
        md_addr   = '0;
        md_len    = '0;
        md_id     = '0;
        md_last_b = 1;
        md_tags.delete();
        md_err    = 0;
    endtask

    task automatic model_cycle(input bit step);
        int n;
        bit pw, bw, head, exp_mrr, exp_pv, exp_bv, pop, orphan;
        n  = md_tags.size();
        pw = 0;
        bw = 0;
        if (resetN && !md_pend && n < 4) begin
            if (p_ar_valid && (!b_ar_valid || md_last_b)) pw = 1;
            else if (b_ar_valid) bw = 1;
        end
        if (n == 0) begin
            head    = 0;
            exp_mrr = 1;
            exp_pv  = 0;
            exp_bv  = 0;
        end else begin
            head    = md_tags[0];
            exp_mrr = head ? b_r_ready : p_r_ready;
            exp_pv  = m_r_valid && !head;
            exp_bv  = m_r_valid && head;
        end
        chk("cmp_p_ar_ready", p_ar_ready, pw);
        chk("cmp_b_ar_ready", b_ar_ready, bw);
        chk("cmp_m_ar_valid", m_ar_valid, md_pend);
        chk("cmp_m_ar_addr", m_ar_addr, md_addr);
        chk("cmp_m_ar_len", m_ar_len, md_len);
        chk("cmp_m_ar_id", m_ar_id, md_id);
        chk("cmp_m_r_ready", m_r_ready, exp_mrr);
        chk("cmp_p_r_valid", p_r_valid, exp_pv);
        chk("cmp_b_r_valid", b_r_valid, exp_bv);
        chk("cmp_p_r_bcast", {p_r_last, p_r_data, p_r_id}, {m_r_last, m_r_data, m_r_id});
        chk("cmp_b_r_bcast", {b_r_last, b_r_data, b_r_id}, {m_r_last, m_r_data, m_r_id});
        chk("cmp_outstanding", outstanding, n);
        chk("cmp_err_orphan", err_orphan_r, md_err);
        if (step) begin
            pop    = (n > 0) && m_r_valid && exp_mrr && m_r_last;
            orphan = (n == 0) && m_r_valid;
            if (pop) void'(md_tags.pop_front());
            if (md_pend) begin
                if (m_ar_ready) md_pend = 0;
            end else if (pw || bw) begin
                md_pend   = 1;
                md_addr   = pw ? p_ar_addr : b_ar_addr;
                md_len    = pw ? p_ar_len : b_ar_len;
                md_id     = pw ? p_ar_id : b_ar_id;
                md_last_b = bw;
                md_tags.push_back(bw);
            end
            if (orphan) md_err = 1;
        end
    endtask

    // Inputs change just after posedge, so at negedge they equal what the next edge sees.
    always @(negedge clk) begin
        if (!resetN) begin
            model_reset();
            model_cycle(0);
        end else begin
            model_cycle(1);
        end
    end

    always @(negedge resetN) model_reset();

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_ar_valid = 0; p_ar_addr = '0; p_ar_len = '0; p_ar_id = '0;
        b_ar_valid = 0; b_ar_addr = '0; b_ar_len = '0; b_ar_id = '0;
        m_ar_ready = 0;
        m_r_valid = 0; m_r_last = 0; m_r_data = '0; m_r_id = '0;
        p_r_ready = 1; b_r_ready = 1;
    endtask

    task automatic do_reset();
        resetN = 0;
        idle_inputs();
        tick();
        resetN = 1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        idle_inputs();
        #1;
        // reset state
        chk("rst_m_ar_valid", m_ar_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_orphan_r, 0);
        chk("rst_m_r_ready", m_r_ready, 1);
        tick();
        tick();
        resetN = 1;

        // 1: P only
        p_ar_valid = 1; p_ar_addr = 16'h0eef; p_ar_len = 0; p_ar_id = 5;
        #1 chk("t1_p_ar_ready", p_ar_ready, 1);
        tick();
        p_ar_valid = 0;
        #1;
        chk("t1_m_ar_valid", m_ar_valid, 1);
        chk("t1_m_ar_payload", {m_ar_addr, m_ar_len, m_ar_id}, {16'h0eef, 8'd0, 8'd5});
        chk("t1_outstanding", outstanding, 1);
        m_ar_ready = 1;
        tick();
        m_ar_ready = 0;
        #1 chk("t1_m_ar_dropped", m_ar_valid, 0);
        m_r_valid = 1; m_r_last = 1; m_r_data = 8'h3c; m_r_id = 5;
        #1;
        chk("t1_p_r_valid", p_r_valid, 1);
        chk("t1_b_r_valid", b_r_valid, 0);
        chk("t1_p_r_data", p_r_data, 8'h3c);
        tick();
        m_r_valid = 0; m_r_last = 0;
        #1 chk("t1_out_zero", outstanding, 0);

        // 2: tie after reset -> P then B
        do_reset();
        p_ar_valid = 1; p_ar_addr = 16'h1111; p_ar_id = 1;
        b_ar_valid = 1; b_ar_addr = 16'h2222; b_ar_id = 2;
        #1;
        chk("t2_p_ready", p_ar_ready, 1);
        chk("t2_b_ready", b_ar_ready, 0);
        tick();
        p_ar_valid = 0; m_ar_ready = 1;
        #1;
        chk("t2_first_addr", m_ar_addr, 16'h1111);
        chk("t2_out1", outstanding, 1);
        tick();
        #1 chk("t2_b_ready2", b_ar_ready, 1);
        tick();
        b_ar_valid = 0;
        #1;
        chk("t2_second_addr", m_ar_addr, 16'h2222);
        chk("t2_out2", outstanding, 2);
        tick();
        m_ar_ready = 0; m_r_valid = 1; m_r_last = 1; m_r_data = 8'h11;
        #1;
        chk("t2_route_p", {p_r_valid, b_r_valid}, 2'b10);
        tick();
        #1;
        chk("t2_out_after_p", outstanding, 1);
        chk("t2_route_b", {p_r_valid, b_r_valid}, 2'b01);
        tick();
        m_r_valid = 0; m_r_last = 0;
        #1 chk("t2_out_end", outstanding, 0);

        // 3: fill the tag FIFO with B bursts
        do_reset();
        b_ar_valid = 1; b_ar_len = 3; b_ar_addr = 16'h4000; m_ar_ready = 1;
        repeat (10) tick();
        chk("t3_out_full", outstanding, 4);
        chk("t3_ready_full", b_ar_ready, 0);
        m_r_valid = 1; m_r_last = 0;
        repeat (3) tick();
        chk("t3_no_pop_nonlast", outstanding, 4);
        chk("t3_still_blocked", b_ar_ready, 0);
        m_r_last = 1;
        tick();
        m_r_valid = 0; m_r_last = 0;
        #1;
        chk("t3_out_after_pop", outstanding, 3);
        chk("t3_ready_after_pop", b_ar_ready, 1);
        tick();
        b_ar_valid = 0;
        m_r_valid = 1; m_r_last = 1;
        for (int i = 0; i < 30; i++) begin
            if (outstanding == 0 && !m_ar_valid) break;
            tick();
        end
        m_r_valid = 0; m_r_last = 0;
        #1 chk("t3_drained", outstanding, 0);

        // 4: backpressure on P holds the channel
        do_reset();
        m_ar_ready = 1;
        p_ar_valid = 1; b_ar_valid = 1;
        tick();
        p_ar_valid = 0;
        tick();
        tick();
        b_ar_valid = 0;
        tick();
        m_ar_ready = 0;
        p_r_ready = 0; m_r_valid = 1; m_r_last = 0; m_r_data = 8'ha5;
        #1;
        chk("t4_out2", outstanding, 2);
        chk("t4_m_r_ready", m_r_ready, 0);
        chk("t4_p_r_data", p_r_data, 8'ha5);
        tick();
        chk("t4_hold", {p_r_valid, b_r_valid, outstanding}, {2'b10, 3'd2});
        p_r_ready = 1; m_r_last = 1;
        tick();
        chk("t4_b_after", {p_r_valid, b_r_valid, outstanding}, {2'b01, 3'd1});
        tick();
        m_r_valid = 0; m_r_last = 0;

        // 5: orphan beat
        #1 chk("t5_err_before", err_orphan_r, 0);
        m_r_valid = 1;
        #1;
        chk("t5_drain_ready", m_r_ready, 1);
        chk("t5_no_route", {p_r_valid, b_r_valid}, 2'b00);
        tick();
        m_r_valid = 0;
        #1 chk("t5_err_set", err_orphan_r, 1);
        repeat (3) tick();
        chk("t5_err_sticky", err_orphan_r, 1);

        // 6: asynchronous reset mid-burst
        m_ar_ready = 1; p_ar_valid = 1; b_ar_valid = 1;
        tick();
        tick();
        tick();
        p_ar_valid = 0; b_ar_valid = 0; m_ar_ready = 0;
        #1;
        chk("t6_pre_send", {m_ar_valid, outstanding, err_orphan_r}, {1'b1, 3'd2, 1'b1});
        #2 resetN = 0;
        #1;
        chk("t6_rst_m_ar_valid", m_ar_valid, 0);
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_err", err_orphan_r, 0);
        tick();
        resetN = 1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            p_ar_valid = ($urandom_range(0, 2) != 0);
            p_ar_addr  = 16'($urandom);
            p_ar_len   = 8'($urandom);
            p_ar_id    = 8'($urandom);
            b_ar_valid = ($urandom_range(0, 2) != 0);
            b_ar_addr  = 16'($urandom);
            b_ar_len   = 8'($urandom);
            b_ar_id    = 8'($urandom);
            m_ar_ready = ($urandom_range(0, 2) != 0);
            m_r_valid  = ($urandom_range(0, 1) != 0);
            m_r_last   = ($urandom_range(0, 2) == 0);
            m_r_data   = 8'($urandom);
            m_r_id     = 8'($urandom);
            p_r_ready  = ($urandom_range(0, 3) != 0);
            b_r_ready  = ($urandom_range(0, 3) != 0);
            resetN     = (c % 700 != 699);
            tick();
        end
        resetN = 1;
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
